// File: rtl/sram_axi_bridge.sv
// Bridges a single-outstanding SRAM-like CPU port onto AXI read/write channels.
// One transaction at a time; all AXI-side controls are registered.
module sram_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [31:0]       rdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       axi_rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        size_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic              aw_done_now;
    logic              w_done_now;

    assign addr_ok   = req && (state == IDLE);
    assign araddr    = addr_r;
    assign awaddr    = addr_r;
    assign arsize    = {1'b0, size_r};
    assign awsize    = {1'b0, size_r};
    assign axi_wdata = wdata_r;
    assign axi_wstrb = wstrb_r;

    // A channel counts as finished if it already handshook or handshakes now.
    assign aw_done_now = !awvalid || awready;
    assign w_done_now  = !wvalid || wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            addr_r  <= '0;
            size_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
            rdata   <= '0;
            data_ok <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            data_ok <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_r  <= addr;
                    size_r  <= (size == 2'b11) ? 2'b10 : size;
                    wdata_r <= wdata;
                    wstrb_r <= wstrb;
                    if (wr) begin
                        state   <= W;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else begin
                        state   <= AR;
                        arvalid <= 1'b1;
                    end
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= R;
                end
                R: if (rvalid) begin
                    rdata   <= axi_rdata;
                    rready  <= 1'b0;
                    data_ok <= 1'b1;
                    state   <= IDLE;
                end
                W: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done_now && w_done_now) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: if (bvalid) begin
                    bready  <= 1'b0;
                    data_ok <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed transaction table plus random transactions
// checked cycle by cycle against a handshake-schedule model.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        addr_ok, data_ok;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready = 1'b0;
    logic [31:0] axi_rdata = '0;
    logic        rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;

    sram_axi_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // d1/d2/d3: wait cycles before arready/rvalid (read) or awready/wready/bvalid (write)
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d1, d2, d3;
        logic [31:0] rdv;
        bit          poke;
        bit          b2b;
        int          exp_lat;
        logic [2:0]  exp_xsize;
    } txn_t;

    txn_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic txn_t mk(logic w, logic [1:0] s, logic [31:0] a, logic [31:0] wd,
                                logic [3:0] ws, int d1, int d2, int d3, logic [31:0] rdv,
                                bit poke, bit b2b, int lat, logic [2:0] xs);
        txn_t t;
        t.wr = w; t.size = s; t.addr = a; t.wdata = wd; t.wstrb = ws;
        t.d1 = d1; t.d2 = d2; t.d3 = d3; t.rdv = rdv; t.poke = poke; t.b2b = b2b;
        t.exp_lat = lat; t.exp_xsize = xs;
        return t;
    endfunction

    // Model: data_ok cycle counted from the addr_ok cycle.
    function automatic int model_lat(txn_t t);
        if (!t.wr) return 3 + t.d1 + t.d2;
        return 3 + ((t.d1 > t.d2) ? t.d1 : t.d2) + t.d3;
    endfunction

    function automatic logic [2:0] model_xsize(logic [1:0] s);
        return (s == 2'd3) ? 3'd2 : {1'b0, s};
    endfunction

    task automatic drive_req(input txn_t t);
        req = 1'b1; wr = t.wr; size = t.size; addr = t.addr; wdata = t.wdata; wstrb = t.wstrb;
    endtask

    task automatic idle_inputs();
        req = 1'b0; wr = $urandom_range(0, 1); size = $urandom_range(0, 3);
        addr = $urandom; wdata = $urandom; wstrb = $urandom_range(0, 15);
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        axi_rdata = $urandom;
    endtask

    // Entered at posedge+1 of the first transaction's addr_ok cycle.
    task automatic run_q();
        bit issued = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            txn_t t = q[i];
            bit   nb = (i + 1 < q.size()) && q[i+1].b2b;
            int   cb = 2 + ((t.d1 > t.d2) ? t.d1 : t.d2);
            if (!issued) begin
                idle_inputs();
                drive_req(t);
                @(negedge clk);
                chk("addr_ok_issue", addr_ok, 1);
                @(posedge clk); #1;
            end
            for (int c = 1; c <= t.exp_lat; c++) begin
                logic e_arv, e_rr, e_awv, e_wv, e_br;
                idle_inputs();
                if (t.poke && c < t.exp_lat) req = 1'b1;
                if (!t.wr) begin
                    arready = (c == 1 + t.d1);
                    rvalid  = (c == 2 + t.d1 + t.d2);
                    if (rvalid) axi_rdata = t.rdv;
                end else begin
                    awready = (c == 1 + t.d1);
                    wready  = (c == 1 + t.d2);
                    bvalid  = (c == cb + t.d3);
                end
                if (c == t.exp_lat && nb) drive_req(q[i+1]);
                @(negedge clk);
                e_arv = !t.wr && (c <= 1 + t.d1);
                e_rr  = !t.wr && (c >= 2 + t.d1) && (c <= 2 + t.d1 + t.d2);
                e_awv = t.wr && (c <= 1 + t.d1);
                e_wv  = t.wr && (c <= 1 + t.d2);
                e_br  = t.wr && (c >= cb) && (c <= cb + t.d3);
                chk("arvalid", arvalid, e_arv);
                chk("rready", rready, e_rr);
                chk("awvalid", awvalid, e_awv);
                chk("wvalid", wvalid, e_wv);
                chk("bready", bready, e_br);
                chk("data_ok", data_ok, c == t.exp_lat);
                if (req) chk("addr_ok", addr_ok, c == t.exp_lat);
                if (e_arv) begin
                    chk("araddr", araddr, t.addr);
                    chk("arsize", arsize, t.exp_xsize);
                end
                if (e_awv) begin
                    chk("awaddr", awaddr, t.addr);
                    chk("awsize", awsize, t.exp_xsize);
                end
                if (e_wv) begin
                    chk("axi_wdata", axi_wdata, t.wdata);
                    chk("axi_wstrb", axi_wstrb, t.wstrb);
                end
                if (c == t.exp_lat && !t.wr) last_rd = t.rdv;
                chk("rdata", rdata, last_rd);
                @(posedge clk); #1;
            end
            issued = nb;
        end
        idle_inputs();
        q.delete();
    endtask

    initial begin
        // Reset state: controls low, addr_ok follows req combinationally.
        idle_inputs();
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr_ok_lo", addr_ok, 0);
        req = 1'b1; #1;
        chk("rst_addr_ok_hi", addr_ok, 1);
        req = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed table
        q.push_back(mk(0, 2'd2, 32'h1FC0_0000, 32'h0, 4'h0, 0, 0, 0, 32'h2408_0001, 0, 0, 3, 3'b010));
        q.push_back(mk(1, 2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 2, 1, 32'h0, 0, 0, 6, 3'b001));
        q.push_back(mk(0, 2'd0, 32'h0000_0100, 32'h0, 4'h0, 5, 1, 0, 32'hCAFE_F00D, 1, 0, 9, 3'b000));
        q.push_back(mk(0, 2'd3, 32'h0000_0204, 32'h0, 4'h0, 0, 2, 0, 32'h1234_5678, 0, 0, 5, 3'b010));
        q.push_back(mk(1, 2'd2, 32'h0000_0300, 32'h55AA_55AA, 4'hF, 1, 1, 0, 32'h0, 0, 1, 4, 3'b010));
        q.push_back(mk(1, 2'd0, 32'h0000_0008, 32'h0000_00A5, 4'h1, 3, 0, 2, 32'h0, 0, 1, 8, 3'b000));
        q.push_back(mk(0, 2'd1, 32'h0000_0040, 32'h0, 4'h0, 1, 0, 0, 32'h0BAD_CAFE, 0, 1, 4, 3'b001));
        run_q();

        // Random transactions against the model
        for (int i = 0; i < 60; i++) begin
            txn_t t;
            t = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom, $urandom,
                   $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, $urandom_range(0, 1),
                   (i > 0) && ($urandom_range(0, 2) == 0), 0, 3'b000);
            t.exp_lat   = model_lat(t);
            t.exp_xsize = model_xsize(t.size);
            q.push_back(t);
        end
        run_q();

        // Reset while waiting in R abandons the read.
        idle_inputs();
        drive_req(mk(0, 2'd2, 32'h0000_0500, 32'h0, 4'h0, 0, 0, 0, 32'h0, 0, 0, 0, 3'b010));
        @(negedge clk);
        chk("mid_addr_ok", addr_ok, 1);
        @(posedge clk); #1;
        idle_inputs();
        arready = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("mid_rready", rready, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_data_ok", data_ok, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_araddr", araddr, 0);
        req = 1'b1; #1;
        chk("mid_rst_addr_ok", addr_ok, 1);
        req = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rvalid = 1'b1; bvalid = 1'b1; axi_rdata = $urandom;
            @(negedge clk);
            chk("post_rst_data_ok", data_ok, 0);
            chk("post_rst_rready", rready, 0);
            chk("post_rst_arvalid", arvalid, 0);
            chk("post_rst_rdata", rdata, 0);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; bvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
